// File: rtl/rvfi_check_sequencer.sv
// -----------------------------------------------------------------------------
// rvfi_check_sequencer
//
// Cycle sequencer for the single-shot RVFI property checkers. After reset is
// released it holds the core in reset for RESET_CYCLES clocks. It then opens a
// trigger window [TRIG_MIN, TRIG_MAX]. In that window it issues exactly one
// `trig`, on the first cycle where the solver requests one and the monitored
// channel retires an instruction. Finally it issues exactly one `check` at
// CHECK_CYCLE.
//
// Ports:
//   clock       in   sole clock, rising edge
//   reset       in   asynchronous active-high reset, returns the block to RST
//   trig_req    in   solver-driven request for a trigger this cycle
//   insn_valid  in   rvfi_valid of the monitored channel
//   core_reset  out  registered reset for the core and checkers
//   trig        out  single-cycle trigger (combinational, same cycle as data)
//   check       out  single-cycle check strobe (combinational)
//   cycle       out  cycles since reset release, saturating at 2^CW-1
//   trig_cycle  out  value of `cycle` captured in the trigger cycle
//   armed       out  trigger seen, check still pending
//   done        out  sticky completion flag
//   missed      out  sticky flag: the window closed without a trigger
// -----------------------------------------------------------------------------
module rvfi_check_sequencer #(
  parameter int RESET_CYCLES = 1,
  parameter int TRIG_MIN     = 1,
  parameter int TRIG_MAX     = 15,
  parameter int CHECK_CYCLE  = 20,
  parameter int CW           = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          trig_req,
  input  logic          insn_valid,
  output logic          core_reset,
  output logic          trig,
  output logic          check,
  output logic [CW-1:0] cycle,
  output logic [CW-1:0] trig_cycle,
  output logic          armed,
  output logic          done,
  output logic          missed
);

  localparam logic [1:0] ST_RST   = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_ARMED = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Cycle-number constants at counter width, so all compares are same-width.
  localparam logic [CW-1:0] RST_LAST_W  = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] TRIG_MIN_W  = CW'(TRIG_MIN);
  localparam logic [CW-1:0] TRIG_MAX_W  = CW'(TRIG_MAX);
  localparam logic [CW-1:0] CHECK_W     = CW'(CHECK_CYCLE);
  localparam logic [CW-1:0] CYCLE_SAT_W = {CW{1'b1}};

  logic [1:0]    state_reg, state_next;
  logic [CW-1:0] cycle_reg;
  logic [CW-1:0] trig_cycle_reg, trig_cycle_next;
  logic          core_reset_reg, core_reset_next;
  logic          armed_reg, armed_next;
  logic          done_reg, done_next;
  logic          missed_reg, missed_next;
  logic          trig_w, check_w;
  logic          in_window;

  assign in_window = (cycle_reg >= TRIG_MIN_W) && (cycle_reg <= TRIG_MAX_W);

  // Free-running elapsed-cycle counter. It saturates instead of wrapping, so
  // a late sample in DONE never aliases back into the trigger window.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cycle_reg <= '0;
    end else if (cycle_reg != CYCLE_SAT_W) begin
      cycle_reg <= cycle_reg + CW'(1);
    end
  end

  always_comb begin
    state_next      = state_reg;
    trig_cycle_next = trig_cycle_reg;
    core_reset_next = core_reset_reg;
    armed_next      = armed_reg;
    done_next       = done_reg;
    missed_next     = missed_reg;
    trig_w          = 1'b0;
    check_w         = 1'b0;

    case (state_reg)
      ST_RST: begin
        core_reset_next = 1'b1;
        // Leave on the last reset cycle so core_reset drops on this edge.
        if (cycle_reg == RST_LAST_W) begin
          state_next      = ST_WAIT;
          core_reset_next = 1'b0;
        end
      end

      ST_WAIT: begin
        trig_w = trig_req && insn_valid && in_window;
        // A trigger in the last window cycle takes priority over a miss.
        if (trig_w) begin
          trig_cycle_next = cycle_reg;
          armed_next      = 1'b1;
          state_next      = ST_ARMED;
        end else if (cycle_reg == TRIG_MAX_W) begin
          missed_next = 1'b1;
          done_next   = 1'b1;
          state_next  = ST_DONE;
        end
      end

      ST_ARMED: begin
        check_w = (cycle_reg == CHECK_W);
        if (check_w) begin
          armed_next = 1'b0;
          done_next  = 1'b1;
          state_next = ST_DONE;
        end
      end

      ST_DONE: begin
        // Absorbing: only reset leaves this state.
      end

      default: begin
        state_next = ST_RST;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_RST;
      trig_cycle_reg <= '0;
      core_reset_reg <= 1'b1;
      armed_reg      <= 1'b0;
      done_reg       <= 1'b0;
      missed_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      trig_cycle_reg <= trig_cycle_next;
      core_reset_reg <= core_reset_next;
      armed_reg      <= armed_next;
      done_reg       <= done_next;
      missed_reg     <= missed_next;
    end
  end

  assign core_reset = core_reset_reg;
  assign trig       = trig_w;
  assign check      = check_w;
  assign cycle      = cycle_reg;
  assign trig_cycle = trig_cycle_reg;
  assign armed      = armed_reg;
  assign done       = done_reg;
  assign missed     = missed_reg;

endmodule

// File: tb/tb_rvfi_check_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for rvfi_check_sequencer. Two instances share one stimulus stream:
// instance A uses default parameters, and instance B uses RESET_CYCLES=3,
// TRIG_MIN=3. The driver computes the expected outputs of every cycle from a
// closed-form model of the sequencing rules and queues them. A monitor pops
// and compares them on the falling edge, and right after an asynchronous
// reset.
// -----------------------------------------------------------------------------
module tb_rvfi_check_sequencer;

  typedef struct packed {
    logic       core_reset;
    logic       trig;
    logic       check;
    logic       armed;
    logic       done;
    logic       missed;
    logic [7:0] cycle;
    logic [7:0] trig_cycle;
  } exp_t;

  logic clock;
  logic reset;
  logic trig_req;
  logic insn_valid;

  logic       core_reset_a, trig_a, check_a, armed_a, done_a, missed_a;
  logic [7:0] cycle_a, trig_cycle_a;
  logic       core_reset_b, trig_b, check_b, armed_b, done_b, missed_b;
  logic [7:0] cycle_b, trig_cycle_b;

  rvfi_check_sequencer dut_a (
    .clock      (clock),
    .reset      (reset),
    .trig_req   (trig_req),
    .insn_valid (insn_valid),
    .core_reset (core_reset_a),
    .trig       (trig_a),
    .check      (check_a),
    .cycle      (cycle_a),
    .trig_cycle (trig_cycle_a),
    .armed      (armed_a),
    .done       (done_a),
    .missed     (missed_a)
  );

  rvfi_check_sequencer #(.RESET_CYCLES(3), .TRIG_MIN(3)) dut_b (
    .clock      (clock),
    .reset      (reset),
    .trig_req   (trig_req),
    .insn_valid (insn_valid),
    .core_reset (core_reset_b),
    .trig       (trig_b),
    .check      (check_b),
    .cycle      (cycle_b),
    .trig_cycle (trig_cycle_b),
    .armed      (armed_b),
    .done       (done_b),
    .missed     (missed_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int   checks = 0;
  int   errors = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  event mon_ev;

  // Model state: cycles since release, and the cycle each instance triggered
  // in (-1 means no trigger yet in this epoch).
  int n         = 0;
  int trig_at_a = -1;
  int trig_at_b = -1;

  // Expected outputs in cycle n, derived directly from the sequencing rules.
  function automatic exp_t model(int cyc, int trig_at, bit req, bit val,
                                 int rc, int tmin, int tmax, int cc);
    exp_t e;
    e.cycle      = 8'(cyc);
    e.core_reset = (cyc < rc);
    e.trig       = (trig_at < 0) && req && val && (cyc >= tmin) && (cyc <= tmax);
    e.armed      = (trig_at >= 0) && (cyc <= cc);
    e.check      = (trig_at >= 0) && (cyc == cc);
    e.done       = (trig_at >= 0) ? (cyc > cc) : (cyc > tmax);
    e.missed     = (trig_at < 0) && (cyc > tmax);
    e.trig_cycle = (trig_at >= 0) ? 8'(trig_at) : 8'd0;
    return e;
  endfunction

  task automatic cmp_one(string tag, string nm, int act, int req_v);
    checks++;
    if (act != req_v) begin
      errors++;
      $display("FAIL %s.%s at %0t: got %0d, expected %0d", tag, nm, $time, act, req_v);
    end
  endtask

  task automatic cmp_rec(string tag, exp_t e, logic cr, logic tg, logic ck,
                         logic ar, logic dn, logic ms, logic [7:0] cy,
                         logic [7:0] tc);
    cmp_one(tag, "core_reset", int'(cr), int'(e.core_reset));
    cmp_one(tag, "trig",       int'(tg), int'(e.trig));
    cmp_one(tag, "check",      int'(ck), int'(e.check));
    cmp_one(tag, "armed",      int'(ar), int'(e.armed));
    cmp_one(tag, "done",       int'(dn), int'(e.done));
    cmp_one(tag, "missed",     int'(ms), int'(e.missed));
    cmp_one(tag, "cycle",      int'(cy), int'(e.cycle));
    cmp_one(tag, "trig_cycle", int'(tc), int'(e.trig_cycle));
  endtask

  // Monitor: consumes expectations independently of the driver.
  initial begin
    forever begin
      @(negedge clock or mon_ev);
      if (q_a.size() > 0)
        cmp_rec("A", q_a.pop_front(), core_reset_a, trig_a, check_a, armed_a,
                done_a, missed_a, cycle_a, trig_cycle_a);
      if (q_b.size() > 0)
        cmp_rec("B", q_b.pop_front(), core_reset_b, trig_b, check_b, armed_b,
                done_b, missed_b, cycle_b, trig_cycle_b);
    end
  end

  // One cycle: drive inputs, queue expectations, advance the model past the edge.
  task automatic step(input bit req, input bit val);
    exp_t ea, eb;
    trig_req   = req;
    insn_valid = val;
    ea = model(n, trig_at_a, req, val, 1, 1, 15, 20);
    eb = model(n, trig_at_b, req, val, 3, 3, 15, 20);
    q_a.push_back(ea);
    q_b.push_back(eb);
    @(posedge clock);
    #1;
    if (ea.trig) trig_at_a = n;
    if (eb.trig) trig_at_b = n;
    if (n < 255) n++;
  endtask

  // Asynchronous reset; the reset state is checked 1 time unit after assertion.
  task automatic do_reset();
    exp_t r;
    r            = '0;
    r.core_reset = 1'b1;
    reset = 1'b1;
    #1;
    n         = 0;
    trig_at_a = -1;
    trig_at_b = -1;
    q_a.push_back(r);
    q_b.push_back(r);
    -> mon_ev;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic report(string name);
    $display("epoch %s: A trig_at=%0d, B trig_at=%0d, last cycle=%0d",
             name, trig_at_a, trig_at_b, n);
  endtask

  initial begin
    int len, rst_at, dens, d;
    reset      = 1'b1;
    trig_req   = 1'b0;
    insn_valid = 1'b0;

    // Nominal: requests held from cycle 1.
    do_reset();
    repeat (25) step(n >= 1, n >= 1);
    report("nominal");

    // No valid instruction: window closes, missed.
    do_reset();
    repeat (25) step(1'b1, 1'b0);
    report("no_valid");

    // Window edges: pulses just outside the window.
    do_reset();
    repeat (24) step(n == 0 || n == 16, n == 0 || n == 16);
    report("edges_outside");

    // Window edge: pulse on the last window cycle.
    do_reset();
    repeat (24) step(n == 15, n == 15);
    report("edge_last");

    // Repeated requests for cycles 3-19.
    do_reset();
    repeat (24) step(n >= 3 && n <= 19, n >= 3 && n <= 19);
    report("repeated");

    // Reset mid-flight at cycle 10 while armed, then a full rerun.
    do_reset();
    repeat (10) step(n >= 1, n >= 1);
    #6;
    do_reset();
    repeat (25) step(n >= 1, n >= 1);
    report("reset_midflight");

    // Requests at cycles 2 and 3 (instance B must ignore 2 and take 3).
    do_reset();
    repeat (24) step(n == 2 || n == 3, n == 2 || n == 3);
    report("late_window");

    // Counter saturation.
    do_reset();
    repeat (262) step(1'b1, 1'b1);
    report("saturate");

    // Randomized epochs, some with asynchronous reset part-way.
    for (int ep = 0; ep < 30; ep++) begin
      do_reset();
      len    = int'($urandom_range(12, 40));
      rst_at = ($urandom % 4 == 0) ? int'($urandom_range(2, len - 1)) : -1;
      dens   = int'($urandom_range(2, 12));
      for (int k = 0; k < len; k++) begin
        if (k == rst_at) begin
          d = ($urandom % 2 == 0) ? int'($urandom_range(1, 2)) : int'($urandom_range(6, 7));
          #(d);
          do_reset();
        end
        step($urandom % dens == 0, $urandom % 2 == 0);
      end
      report("random");
    end

    @(negedge clock);
    #1;
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending, expected 0/0", q_a.size(), q_b.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
